mips_exec_datapath: RTL and testbench

// - Integer execute/write-back slice of the single-cycle MIPS core: decoder + ALU + 32x32 register file.
// - Decodes one instruction per clock. Executes R-type and immediate ALU ops and writes the result to the register file.
// - Raises sticky halted on syscall.
// - Memory, branch and PC logic sit outside this block. The core feeds inst and consumes halted.

---
 rtl/mips_exec_datapath.sv | 141 ++++++++++++++
 tb/tb_mips_exec_datapath.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_exec_datapath.sv
// ============================================================================
// Module   : mips_exec_datapath
// Purpose  : Integer execute/write-back slice: decoder, ALU and 32x32 register
//            file with sticky halt on syscall. Optional OVERFLOW_TRAP_EN
//            suppresses the write on signed overflow of add/sub/addi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_exec_datapath (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic [4:0]  dbg_rnum,
  output logic [31:0] dbg_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_num,
  output logic [31:0] wb_data,
  output logic        halted
);

`ifdef OVERFLOW_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  logic [31:0] regs_q [32];
  logic        halted_q, halted_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] seimm, zeimm, rs_val, rt_val;
  logic [31:0] sum_rr, diff_rr, sum_ri;
  logic        ovf_add, ovf_sub, ovf_addi;

  logic [31:0] alu;
  logic [4:0]  dest;
  logic        writes, ovf, is_sys, go;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sh    = inst[10:6];
  assign fn    = inst[5:0];
  assign imm   = inst[15:0];
  assign seimm = {{16{imm[15]}}, imm};
  assign zeimm = {16'h0000, imm};

  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];

  assign sum_rr  = rs_val + rt_val;
  assign diff_rr = rs_val - rt_val;
  assign sum_ri  = rs_val + seimm;

  // Signed overflow: operands agree in sign (after negation for sub) but result differs.
  assign ovf_add  = (rs_val[31] == rt_val[31]) && (sum_rr[31]  != rs_val[31]);
  assign ovf_sub  = (rs_val[31] != rt_val[31]) && (diff_rr[31] != rs_val[31]);
  assign ovf_addi = (rs_val[31] == seimm[31])  && (sum_ri[31]  != rs_val[31]);

  always_comb begin
    alu    = 32'h0;
    dest   = rt;
    writes = 1'b0;
    ovf    = 1'b0;
    is_sys = 1'b0;
    if (op == OP_RTYPE) begin
      dest   = rd;
      writes = 1'b1;
      case (fn)
        6'h20: begin alu = sum_rr;  ovf = ovf_add; end
        6'h21: alu = sum_rr;
        6'h22: begin alu = diff_rr; ovf = ovf_sub; end
        6'h23: alu = diff_rr;
        6'h24: alu = rs_val & rt_val;
        6'h25: alu = rs_val | rt_val;
        6'h26: alu = rs_val ^ rt_val;
        6'h27: alu = ~(rs_val | rt_val);
        6'h2A: alu = {31'h0, $signed(rs_val) < $signed(rt_val)};
        6'h2B: alu = {31'h0, rs_val < rt_val};
        6'h00: alu = rt_val << sh;
        6'h02: alu = rt_val >> sh;
        6'h03: alu = $unsigned($signed(rt_val) >>> sh);
        6'h04: alu = rt_val << rs_val[4:0];
        6'h06: alu = rt_val >> rs_val[4:0];
        6'h07: alu = $unsigned($signed(rt_val) >>> rs_val[4:0]);
        6'h0C: begin writes = 1'b0; is_sys = 1'b1; end
        default: writes = 1'b0;
      endcase
    end else begin
      writes = 1'b1;
      case (op)
        OP_ADDI:  begin alu = sum_ri; ovf = ovf_addi; end
        OP_ADDIU: alu = sum_ri;
        OP_SLTI:  alu = {31'h0, $signed(rs_val) < $signed(seimm)};
        OP_SLTIU: alu = {31'h0, rs_val < seimm};
        OP_ANDI:  alu = rs_val & zeimm;
        OP_ORI:   alu = rs_val | zeimm;
        OP_XORI:  alu = rs_val ^ zeimm;
        OP_LUI:   alu = {imm, 16'h0000};
        default:  writes = 1'b0;
      endcase
    end
  end

  assign go       = inst_valid & ~halted_q;
  assign wb_en    = go & writes & ~(TRAP_EN & ovf) & (dest != 5'd0);
  assign wb_num   = dest;
  assign wb_data  = alu;
  assign halted_d = halted_q | (go & is_sys);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      halted_q <= 1'b0;
    end else begin
      if (wb_en) regs_q[wb_num] <= wb_data;
      halted_q <= halted_d;
    end
  end

  assign dbg_rdata = (dbg_rnum == 5'd0) ? 32'h0 : regs_q[dbg_rnum];
  assign halted    = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_exec_datapath.sv
// ============================================================================
// Module   : tb_mips_exec_datapath
// Purpose  : Directed vector bench for mips_exec_datapath (honours OVERFLOW_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_exec_datapath;

`ifdef OVERFLOW_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst;
  logic        inst_valid;
  logic [4:0]  dbg_rnum;
  logic [31:0] dbg_rdata;
  logic        wb_en;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        halted;

  int tests = 0;
  int fails = 0;

  mips_exec_datapath dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .inst       (inst),
    .inst_valid (inst_valid),
    .dbg_rnum   (dbg_rnum),
    .dbg_rdata  (dbg_rdata),
    .wb_en      (wb_en),
    .wb_num     (wb_num),
    .wb_data    (wb_data),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        en;
    logic [4:0]  num;
    logic [31:0] data;
    logic [4:0]  reg_n;
    logic [31:0] reg_v;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on negedge, check comb outputs, then check register after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    inst       = v.inst;
    inst_valid = v.valid;
    dbg_rnum   = v.reg_n;
    #1;
    chk($sformatf("v%0d wb_en", idx), {31'h0, wb_en}, {31'h0, v.en});
    if (v.en) begin
      chk($sformatf("v%0d wb_num", idx), {27'h0, wb_num}, {27'h0, v.num});
      chk($sformatf("v%0d wb_data", idx), wb_data, v.data);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d reg%0d", idx, v.reg_n), dbg_rdata, v.reg_v);
  endtask

  initial begin
    vecs[0]  = '{32'h24010005, 1'b1, 1'b1, 5'd1,  32'h00000005, 5'd1,  32'h00000005}; // addiu $1,$0,5
    vecs[1]  = '{32'h2402FFFD, 1'b1, 1'b1, 5'd2,  32'hFFFFFFFD, 5'd2,  32'hFFFFFFFD}; // addiu $2,$0,-3
    vecs[2]  = '{32'h00221820, 1'b1, 1'b1, 5'd3,  32'h00000002, 5'd3,  32'h00000002}; // add $3,$1,$2
    vecs[3]  = '{32'h0041202A, 1'b1, 1'b1, 5'd4,  32'h00000001, 5'd4,  32'h00000001}; // slt $4,$2,$1
    vecs[4]  = '{32'h0041202B, 1'b1, 1'b1, 5'd4,  32'h00000000, 5'd4,  32'h00000000}; // sltu $4,$2,$1
    vecs[5]  = '{32'h3C058000, 1'b1, 1'b1, 5'd5,  32'h80000000, 5'd5,  32'h80000000}; // lui $5,0x8000
    vecs[6]  = '{32'h00053103, 1'b1, 1'b1, 5'd6,  32'hF8000000, 5'd6,  32'hF8000000}; // sra $6,$5,4
    vecs[7]  = '{32'h00053102, 1'b1, 1'b1, 5'd6,  32'h08000000, 5'd6,  32'h08000000}; // srl $6,$5,4
    vecs[8]  = '{32'h24000007, 1'b1, 1'b0, 5'd0,  32'h00000007, 5'd0,  32'h00000000}; // addiu $0,$0,7
    vecs[9]  = '{32'h3C077FFF, 1'b1, 1'b1, 5'd7,  32'h7FFF0000, 5'd7,  32'h7FFF0000}; // lui $7,0x7FFF
    vecs[10] = '{32'h34E7FFFF, 1'b1, 1'b1, 5'd7,  32'h7FFFFFFF, 5'd7,  32'h7FFFFFFF}; // ori $7,$7,0xFFFF
    vecs[11] = '{32'h20E80001, 1'b1, ~TRAP, 5'd8, 32'h80000000, 5'd8,
                 TRAP ? 32'h00000000 : 32'h80000000};                                  // addi $8,$7,1
    vecs[12] = '{32'h24E90001, 1'b1, 1'b1, 5'd9,  32'h80000000, 5'd9,  32'h80000000}; // addiu $9,$7,1
    vecs[13] = '{32'h00224822, 1'b1, 1'b1, 5'd9,  32'h00000008, 5'd9,  32'h00000008}; // sub $9,$1,$2
    vecs[14] = '{32'h00225024, 1'b1, 1'b1, 5'd10, 32'h00000005, 5'd10, 32'h00000005}; // and $10,$1,$2
    vecs[15] = '{32'h00225027, 1'b1, 1'b1, 5'd10, 32'h00000002, 5'd10, 32'h00000002}; // nor $10,$1,$2
    vecs[16] = '{32'h382BFFFF, 1'b1, 1'b1, 5'd11, 32'h0000FFFA, 5'd11, 32'h0000FFFA}; // xori $11,$1,0xFFFF
    vecs[17] = '{32'h2C2CFFFF, 1'b1, 1'b1, 5'd12, 32'h00000001, 5'd12, 32'h00000001}; // sltiu $12,$1,-1
    vecs[18] = '{32'h282CFFFF, 1'b1, 1'b1, 5'd12, 32'h00000000, 5'd12, 32'h00000000}; // slti $12,$1,-1
    vecs[19] = '{32'h00216804, 1'b1, 1'b1, 5'd13, 32'h000000A0, 5'd13, 32'h000000A0}; // sllv $13,$1,$1
    vecs[20] = '{32'h00256807, 1'b1, 1'b1, 5'd13, 32'hFC000000, 5'd13, 32'hFC000000}; // srav $13,$5,$1
    vecs[21] = '{32'hFC000000, 1'b1, 1'b0, 5'd0,  32'h00000000, 5'd1,  32'h00000005}; // unknown op
    vecs[22] = '{32'h00221801, 1'b1, 1'b0, 5'd0,  32'h00000000, 5'd3,  32'h00000002}; // unknown fn
    vecs[23] = '{32'h24010009, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd1,  32'h00000005}; // not valid

    rst_b      = 1'b0;
    inst       = 32'h0;
    inst_valid = 1'b0;
    dbg_rnum   = 5'd1;
    #2;
    chk("reset halted", {31'h0, halted}, 32'h0);
    chk("reset reg1", dbg_rdata, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // No bypass: dbg read of the destination shows the old value before the edge.
    @(negedge clk);
    inst = 32'h24010009; inst_valid = 1'b1; dbg_rnum = 5'd1;
    #1;
    chk("nobypass old", dbg_rdata, 32'h00000005);
    @(posedge clk); #1;
    chk("nobypass new", dbg_rdata, 32'h00000009);

    // syscall halts at the next edge and blocks later writes.
    @(negedge clk);
    inst = 32'h0000000C; inst_valid = 1'b1;
    #1;
    chk("syscall wb_en", {31'h0, wb_en}, 32'h0);
    chk("pre-halt", {31'h0, halted}, 32'h0);
    @(posedge clk); #1;
    chk("halted set", {31'h0, halted}, 32'h1);
    @(negedge clk);
    inst = 32'h24010003; dbg_rnum = 5'd1;
    #1;
    chk("halted wb_en", {31'h0, wb_en}, 32'h0);
    @(posedge clk); #1;
    chk("halted reg1", dbg_rdata, 32'h00000009);
    chk("halted sticky", {31'h0, halted}, 32'h1);

    // Asynchronous reset pulse mid-cycle, well away from any rising edge.
    @(negedge clk);
    inst_valid = 1'b0; dbg_rnum = 5'd3;
    #2;
    rst_b = 1'b0;
    #1;
    chk("async halted", {31'h0, halted}, 32'h0);
    chk("async reg3", dbg_rdata, 32'h0);
    dbg_rnum = 5'd5;
    #1;
    chk("async reg5", dbg_rdata, 32'h0);
    rst_b = 1'b1;

    // Core executes again after reset.
    run_vec('{32'h24010005, 1'b1, 1'b1, 5'd1, 32'h00000005, 5'd1, 32'h00000005}, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
